reg_select_arbiter: RTL

REG_SELECT_ARBITER -- requirements
Module: reg_select_arbiter

---
 rtl/reg_select_arbiter_pkg.sv | 27 ++
 rtl/reg_select_arbiter_onehot_decode.sv | 22 ++
 rtl/reg_select_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/reg_select_arbiter_pkg.sv
// Shared types and constants for the register-select arbiter.
// The FSM encoding, the transaction op code and the register map indices live here.
package reg_select_arbiter_pkg;

  localparam int DEFAULT_NUM_REGS = 5;

  // Register map indices
  localparam int CTRL_HPS  = 0;
  localparam int CTRL_CARD = 1;
  localparam int ADDR_HPS  = 2;
  localparam int DATA_HPS  = 3;
  localparam int DATA_CARD = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // OP_BAD marks a request with both read and write high; it completes without a strobe.
  typedef enum logic [1:0] {
    OP_RD  = 2'd0,
    OP_WR  = 2'd1,
    OP_BAD = 2'd2
  } op_t;

endpackage

// File: rtl/reg_select_arbiter_onehot_decode.sv
// Binary register index to one-hot select, with a flag for indices past NUM_REGS.
// Shared by the HPS load strobe and the readback mux select.
module onehot_decode #(
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 5
) (
  input  logic [ADDR_W-1:0]   addr,
  output logic [NUM_REGS-1:0] onehot,
  output logic                out_of_range
);

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr == ADDR_W'(i)) onehot[i] = 1'b1;
    end
    // No bit set means the index is past the last implemented register.
    out_of_range = (onehot == '0);
  end

endmodule

// File: rtl/reg_select_arbiter.sv
// Avalon-MM register select arbiter: turns HPS reads/writes into one-hot load and
// readback strobes, giving card-side writes priority for up to MAX_STALL cycles.
module reg_select_arbiter
  import reg_select_arbiter_pkg::*;
#(
  parameter int                  ADDR_W    = 3,
  parameter int                  NUM_REGS  = DEFAULT_NUM_REGS,
  parameter logic [NUM_REGS-1:0] CARD_MASK = NUM_REGS'(5'b10010),
  parameter int                  MAX_STALL = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                chipselect,
  input  logic                write,
  input  logic                read,
  input  logic [ADDR_W-1:0]   address,
  output logic                waitrequest,
  output logic [NUM_REGS-1:0] hps_load,
  output logic [NUM_REGS-1:0] rd_sel,
  input  logic [NUM_REGS-1:0] card_req,
  output logic [NUM_REGS-1:0] card_load,
  output logic                card_drop,
  output logic                decode_err,
  input  logic                err_clr
);

  localparam int STALL_W = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);

  state_t                state_q, state_d;
  op_t                   op_q, op_d;
  logic [ADDR_W-1:0]     addr_q, addr_d, dec_addr;
  logic [STALL_W-1:0]    stall_q, stall_d;
  logic [NUM_REGS-1:0]   onehot, hps_load_d, rd_sel_d, card_load_d;
  logic                  out_of_range, conflict, override, set_err, waitrequest_d;

  // In IDLE the decoder looks at the live bus so outputs can be registered on accept.
  assign dec_addr = (state_q == IDLE) ? address : addr_q;

  onehot_decode #(
    .ADDR_W  (ADDR_W),
    .NUM_REGS(NUM_REGS)
  ) u_decode (
    .addr        (dec_addr),
    .onehot      (onehot),
    .out_of_range(out_of_range)
  );

  assign conflict = |(onehot & card_req & CARD_MASK);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    stall_d    = stall_q;
    hps_load_d = '0;
    rd_sel_d   = '0;
    override   = 1'b0;
    set_err    = 1'b0;

    case (state_q)
      IDLE: begin
        if (chipselect && (read || write)) begin
          addr_d  = address;
          stall_d = '0;
          state_d = ISSUE;
          if (read && write) begin
            op_d    = OP_BAD;
            set_err = 1'b1;
          end else begin
            op_d    = write ? OP_WR : OP_RD;
            set_err = out_of_range;
            if (!write) rd_sel_d = onehot;
          end
        end
      end

      ISSUE: begin
        if (op_q == OP_WR && conflict && stall_q != STALL_W'(MAX_STALL)) begin
          stall_d = stall_q + 1'b1;
        end else begin
          state_d = DONE;
          if (op_q == OP_WR) begin
            hps_load_d = onehot;
            override   = conflict;
          end
        end
        if (op_q == OP_RD) rd_sel_d = onehot;
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // The card loses its strobe on the bit the HPS wins after the stall limit.
  assign card_load_d   = card_req & CARD_MASK & ~(override ? onehot : '0);
  assign waitrequest_d = (state_d != DONE);

  // NOTE: sequential state uses non-blocking assignments so every register updates together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= OP_RD;
      addr_q      <= '0;
      stall_q     <= '0;
      hps_load    <= '0;
      rd_sel      <= '0;
      card_load   <= '0;
      card_drop   <= 1'b0;
      waitrequest <= 1'b1;
      decode_err  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      stall_q     <= stall_d;
      hps_load    <= hps_load_d;
      rd_sel      <= rd_sel_d;
      card_load   <= card_load_d;
      card_drop   <= override;
      waitrequest <= waitrequest_d;
      decode_err  <= set_err | (decode_err & ~err_clr);
    end
  end

endmodule
